// File: rtl/dreg_shift.sv
// WIDTH-bit edge-triggered register with hold/load/shift/rotate/clear modes,
// a saturating shift counter and a one-cycle completion pulse.
module dreg_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                             CLK,
    input  logic                             R,
    input  logic                             EN,
    input  logic [2:0]                       MODE,
    input  logic [WIDTH-1:0]                 D,
    input  logic                             SIL,
    input  logic                             SIR,
    output logic [WIDTH-1:0]                 Q,
    output logic                             SOR,
    output logic                             SOL,
    output logic [$clog2(WIDTH+1)-1:0]       CNT,
    output logic                             DONE
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHR  = 3'b010,
        M_SHL  = 3'b011,
        M_ROR  = 3'b100,
        M_ROL  = 3'b101,
        M_CLR  = 3'b110,
        M_RSVD = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;
    logic             done_nxt;
    logic             cnt_full;
    logic             cnt_last;

    // Counter saturates at WIDTH; DONE fires only on the WIDTH-1 -> WIDTH step.
    assign cnt_full = (CNT == CW'(WIDTH));
    assign cnt_last = (CNT == CW'(WIDTH - 1));
    assign cnt_inc  = cnt_full ? CNT : CNT + CW'(1);

    assign SOR = Q[0];
    assign SOL = Q[WIDTH-1];

    always_comb begin
        q_nxt    = Q;
        cnt_nxt  = CNT;
        done_nxt = 1'b0;
        if (EN) begin
            case (mode_e'(MODE))
                M_HOLD: ;
                M_LOAD: begin
                    q_nxt   = D;
                    cnt_nxt = '0;
                end
                M_SHR: begin
                    q_nxt    = {SIL, Q[WIDTH-1:1]};
                    cnt_nxt  = cnt_inc;
                    done_nxt = cnt_last;
                end
                M_SHL: begin
                    q_nxt    = {Q[WIDTH-2:0], SIR};
                    cnt_nxt  = cnt_inc;
                    done_nxt = cnt_last;
                end
                M_ROR:  q_nxt = {Q[0], Q[WIDTH-1:1]};
                M_ROL:  q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
                M_CLR: begin
                    q_nxt   = '0;
                    cnt_nxt = '0;
                end
                M_RSVD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            Q    <= '0;
            CNT  <= '0;
            DONE <= 1'b0;
        end else begin
            Q    <= q_nxt;
            CNT  <= cnt_nxt;
            DONE <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dreg_shift.sv
// Randomised and directed checks of dreg_shift (WIDTH=8) against an
// arithmetic reference model evaluated every cycle.
module tb_dreg_shift;

    localparam int unsigned WIDTH = 8;

    logic             CLK = 1'b0;
    logic             R   = 1'b1;
    logic             EN  = 1'b0;
    logic [2:0]       MODE = 3'd0;
    logic [WIDTH-1:0] D   = '0;
    logic             SIL = 1'b0;
    logic             SIR = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             SOR;
    logic             SOL;
    logic [3:0]       CNT;
    logic             DONE;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_cnt  = 0;
    int m_done = 0;
    bit chk_on = 1'b0;

    dreg_shift #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .R   (R),
        .EN  (EN),
        .MODE(MODE),
        .D   (D),
        .SIL (SIL),
        .SIR (SIR),
        .Q   (Q),
        .SOR (SOR),
        .SOL (SOL),
        .CNT (CNT),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on an 8-bit value.
    always @(posedge CLK or negedge R) begin
        if (!R) begin
            m_q = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (EN) begin
                case (int'(MODE))
                    1: begin m_q = int'(D); m_cnt = 0; end
                    2: begin
                        m_done = (m_cnt == 7) ? 1 : 0;
                        m_q = (m_q / 2) + (SIL ? 128 : 0);
                        if (m_cnt < 8) m_cnt++;
                    end
                    3: begin
                        m_done = (m_cnt == 7) ? 1 : 0;
                        m_q = ((m_q * 2) % 256) + (SIR ? 1 : 0);
                        if (m_cnt < 8) m_cnt++;
                    end
                    4: m_q = (m_q / 2) + ((m_q % 2) * 128);
                    5: m_q = ((m_q * 2) % 256) + (m_q / 128);
                    6: begin m_q = 0; m_cnt = 0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            check("q", int'(Q), m_q);
            check("cnt", int'(CNT), m_cnt);
            check("done", int'(DONE), m_done);
            check("sor", int'(SOR), m_q % 2);
            check("sol", int'(SOL), m_q / 128);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic op(input logic [2:0] mode, input logic [7:0] d, input int n);
        EN = 1'b1; MODE = mode; D = d;
        cyc(n);
    endtask

    initial begin
        #3 R = 1'b0;
        @(negedge CLK);
        chk_on = 1'b1;
        check("rst_q", int'(Q), 0);
        cyc(2);
        R = 1'b1;

        // Reset asserted between edges while holding 5A.
        op(3'b001, 8'h5A, 1);
        check("ld5a_q", int'(Q), 'h5A);
        EN = 1'b1; MODE = 3'b010; SIL = 1'b1;
        #2 R = 1'b0;
        #1;
        check("arst_q", int'(Q), 0);
        check("arst_cnt", int'(CNT), 0);
        check("arst_done", int'(DONE), 0);
        #16;
        check("arst_hold_q", int'(Q), 0);
        #1 R = 1'b1;
        @(negedge CLK);

        // Load and enable gating.
        op(3'b001, 8'hA5, 1);
        check("lda5_q", int'(Q), 'hA5);
        check("lda5_cnt", int'(CNT), 0);
        EN = 1'b0; D = 8'hFF;
        cyc(3);
        check("en0_q", int'(Q), 'hA5);

        // Right shift to completion.
        SIL = 1'b1;
        EN = 1'b1; MODE = 3'b010;
        #1 check("shr_sor0", int'(SOR), 1);
        cyc(1);
        check("shr1_q", int'(Q), 'hD2);
        check("shr1_cnt", int'(CNT), 1);
        cyc(6);
        check("shr7_done", int'(DONE), 0);
        cyc(1);
        check("shr8_q", int'(Q), 'hFF);
        check("shr8_cnt", int'(CNT), 8);
        check("shr8_done", int'(DONE), 1);
        cyc(1);
        check("shr9_cnt", int'(CNT), 8);
        check("shr9_done", int'(DONE), 0);

        // Left shift then LOAD override.
        op(3'b001, 8'h01, 1);
        SIR = 1'b0;
        op(3'b011, 8'h00, 7);
        check("shl7_q", int'(Q), 'h80);
        check("shl7_cnt", int'(CNT), 7);
        check("shl7_sol", int'(SOL), 1);
        op(3'b001, 8'h3C, 1);
        check("ldovr_q", int'(Q), 'h3C);
        check("ldovr_cnt", int'(CNT), 0);
        check("ldovr_done", int'(DONE), 0);

        // Rotate, reserved, clear.
        op(3'b001, 8'h81, 1);
        op(3'b101, 8'h00, 1);
        check("rol_q", int'(Q), 'h03);
        check("rol_cnt", int'(CNT), 0);
        op(3'b100, 8'h00, 1);
        check("ror_q", int'(Q), 'h81);
        op(3'b111, 8'hFF, 1);
        check("rsvd_q", int'(Q), 'h81);
        op(3'b110, 8'hFF, 1);
        check("clr_q", int'(Q), 0);
        check("clr_cnt", int'(CNT), 0);

        // Random traffic, shift-heavy so the counter saturates often.
        for (int i = 0; i < 3000; i++) begin
            EN   = ($urandom_range(0, 7) != 0);
            MODE = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(2, 3));
            if ($urandom_range(0, 20) == 0) MODE = 3'b001;
            D    = 8'($urandom);
            SIL  = 1'($urandom);
            SIR  = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 R = 1'b0;
                #5 R = 1'b1;
                @(negedge CLK);
            end else begin
                cyc(1);
            end
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
